// File: rtl/seg7_pkg.sv
// Shared constants for the 2-digit multiplexed 7-segment display path:
// active-high segment patterns, scan FSM encoding and digit indices.
package seg7_pkg;

  // Segment patterns are {g,f,e,d,c,b,a}, 1 = lit
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    S_BLANK0 = 2'd0,
    S_SHOW0  = 2'd1,
    S_BLANK1 = 2'd2,
    S_SHOW1  = 2'd3
  } scan_state_t;

  localparam logic DIGIT_UNITS = 1'b0;
  localparam logic DIGIT_TENS  = 1'b1;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_2digit.sv
// Two-digit time-multiplexed 7-segment driver with per-slot ghost blanking,
// frame-synchronous shadow latching of the BCD inputs and a non-BCD flag.
module seg7_scan_2digit
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] q1,
  input  logic [3:0] q0,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick,
  output logic       bcd_err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  // cnt restarts at each state change, so the lit phase ends early enough
  // that blank + show together span exactly REFRESH_DIV cycles
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [1:0]    AN_INV     = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
  localparam logic [6:0]    SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  scan_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0] sh_q1, sh_q0, sh_q1_nxt, sh_q0_nxt;
  logic tick_nxt;
  logic digit_sel;
  logic [3:0] dec_in;
  logic [6:0] dec_out;
  logic [1:0] an_on;
  logic [6:0] seg_on;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    tick_nxt  = 1'b0;
    sh_q1_nxt = sh_q1;
    sh_q0_nxt = sh_q0;
    if (!enable) begin
      state_nxt = S_BLANK0;
      cnt_nxt   = '0;
      sh_q1_nxt = q1;
      sh_q0_nxt = q0;
    end else begin
      case (state)
        S_BLANK0: if (cnt == BLANK_LAST) begin state_nxt = S_SHOW0;  cnt_nxt = '0; end
        S_SHOW0:  if (cnt == SHOW_LAST)  begin state_nxt = S_BLANK1; cnt_nxt = '0; end
        S_BLANK1: if (cnt == BLANK_LAST) begin state_nxt = S_SHOW1;  cnt_nxt = '0; end
        S_SHOW1: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = S_BLANK0;
            cnt_nxt   = '0;
            tick_nxt  = 1'b1;
            sh_q1_nxt = q1;
            sh_q0_nxt = q0;
          end
        end
        default: begin
          state_nxt = S_BLANK0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // One shared decoder, steered by the digit the next state will light
  assign digit_sel = (state_nxt == S_SHOW1) ? DIGIT_TENS : DIGIT_UNITS;
  assign dec_in    = (digit_sel == DIGIT_TENS) ? sh_q1 : sh_q0;

  bcd_to_seg7 u_dec (
    .bcd (dec_in),
    .seg (dec_out)
  );

  always_comb begin
    an_on  = 2'b00;
    seg_on = SEG_OFF;
    case (state_nxt)
      S_SHOW0: begin
        an_on  = 2'b01;
        seg_on = dec_out;
      end
      S_SHOW1: begin
        if (!(blank_lead && (sh_q1 == 4'd0))) begin
          an_on  = 2'b10;
          seg_on = dec_out;
        end
      end
      default: begin
        an_on  = 2'b00;
        seg_on = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_BLANK0;
      cnt        <= '0;
      sh_q1      <= 4'd0;
      sh_q0      <= 4'd0;
      an         <= AN_INV;
      seg        <= SEG_INV;
      frame_tick <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sh_q1      <= sh_q1_nxt;
      sh_q0      <= sh_q0_nxt;
      an         <= an_on ^ AN_INV;
      seg        <= seg_on ^ SEG_INV;
      frame_tick <= tick_nxt;
      bcd_err    <= (sh_q1_nxt > 4'd9) || (sh_q0_nxt > 4'd9);
    end
  end

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Randomised self-checking bench for seg7_scan_2digit against a frame-position
// reference model (8-cycle slots, 2 blank cycles, active-low outputs).
module tb_seg7_scan_2digit;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 2 * RD;
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [3:0] q1 = 4'd0;
  logic [3:0] q0 = 4'd0;
  logic blank_lead = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic frame_tick;
  logic bcd_err;

  int tests = 0;
  int failed = 0;

  int m_pos;
  logic [3:0] m_sh1, m_sh0;
  logic m_tick, m_bl;

  seg7_scan_2digit #(
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BC),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .q1         (q1),
    .q0         (q0),
    .blank_lead (blank_lead),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  // Model: position within the 16-cycle frame plus digits captured at each boundary
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pos  <= 0;
      m_sh1  <= 4'd0;
      m_sh0  <= 4'd0;
      m_tick <= 1'b0;
      m_bl   <= 1'b0;
    end else begin
      m_bl <= blank_lead;
      if (!enable) begin
        m_pos  <= 0;
        m_tick <= 1'b0;
        m_sh1  <= q1;
        m_sh0  <= q0;
      end else begin
        m_pos  <= (m_pos == FR - 1) ? 0 : m_pos + 1;
        m_tick <= (m_pos == FR - 1);
        if (m_pos == FR - 1) begin
          m_sh1 <= q1;
          m_sh0 <= q0;
        end
      end
    end
  end

  function automatic logic [10:0] exp_vec();
    logic [1:0] an_e;
    logic [6:0] seg_e;
    int slot;
    int off;
    slot  = m_pos / RD;
    off   = m_pos % RD;
    an_e  = 2'b11;
    seg_e = 7'h7F;
    if (off >= BC) begin
      if (slot == 0) begin
        an_e  = 2'b10;
        seg_e = ~DEC[m_sh0];
      end else if (!(m_bl && m_sh1 == 4'd0)) begin
        an_e  = 2'b01;
        seg_e = ~DEC[m_sh1];
      end
    end
    return {an_e, seg_e, m_tick, (m_sh1 > 4'd9) || (m_sh0 > 4'd9)};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q1 = 4'd3;
    q0 = 4'hC;
    @(negedge clk);
    tests++;
    if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
      failed++;
      $display("[TB] FAIL reset_load: got %h, expected %h", {an, seg, frame_tick, bcd_err}, exp_vec());
    end
    enable = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL reset_pre pos %0d: got %h, expected %h", m_pos, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({an, seg, frame_tick, bcd_err} !== {2'b11, 7'h7F, 1'b0, 1'b0}) begin
      failed++;
      $display("[TB] FAIL reset_async: got an=%b seg=%h tick=%b err=%b, expected an=11 seg=7f tick=0 err=0",
               an, seg, frame_tick, bcd_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_scan();
    q1 = 4'd3;
    q0 = 4'd1;
    blank_lead = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL scan cyc %0d pos %0d: got %h, expected %h", i, m_pos, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
    end
  endtask

  task automatic test_midframe();
    for (int i = 0; i < FR + 2 && m_pos != 3; i++) @(negedge clk);
    q1 = 4'd2;
    q0 = 4'd9;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL midframe cyc %0d pos %0d: got %h, expected %h", i, m_pos, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
    end
  endtask

  task automatic test_blank_lead();
    blank_lead = 1'b1;
    q1 = 4'd0;
    q0 = 4'd7;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL blank_lead_on cyc %0d pos %0d: got %h, expected %h", i, m_pos, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
    end
    blank_lead = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL blank_lead_off cyc %0d pos %0d: got %h, expected %h", i, m_pos, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
    end
  endtask

  task automatic test_bad_bcd();
    q1 = 4'd1;
    q0 = 4'hC;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL bad_bcd cyc %0d pos %0d: got %h, expected %h", i, m_pos, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
    end
    q0 = 4'd4;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL bcd_recover cyc %0d pos %0d: got %h, expected %h", i, m_pos, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < FR + 2 && m_pos != 12; i++) @(negedge clk);
    enable = 1'b0;
    q1 = 4'd5;
    q0 = 4'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL disabled cyc %0d: got %h, expected %h", i, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL reenable cyc %0d pos %0d: got %h, expected %h", i, m_pos, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, frame_tick, bcd_err} !== exp_vec()) begin
        failed++;
        $display("[TB] FAIL random cyc %0d pos %0d: got %h, expected %h", i, m_pos, {an, seg, frame_tick, bcd_err}, exp_vec());
      end
      if ($urandom_range(0, 3) == 0) begin
        q1 = 4'($urandom_range(0, 15));
        q0 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 7) == 0) blank_lead = ~blank_lead;
      enable = ($urandom_range(0, 19) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe();
    test_blank_lead();
    test_bad_bcd();
    test_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
